mac_stop_accumulator: RTL and testbench
=======================================

// Module: mac_stop_accumulator
// PURPOSE
//   Accumulate stage of a matrix-multiply engine computing C[MxN] = A[MxK] * B[KxN].
//   - Consumes one pre-computed product A[i][k]*B[k][j] per valid cycle.
//   - Sums K consecutive products into one C element.
//   - At the last k term, presents the finished element with its C address and a write enable for the C memory.
//   - Flags completion after the final element C[M-1][N-1].
// PARAMETERS
//   M                        4       rows of A / rows of C
//   K                        4       cols of A = rows of B (terms per dot product)
//   N                        4       cols of B / cols of C
//   DATA_WIDTH_INIT_MATRIX   32      element width of A and B
//   DATA_WIDTH_RESULT_MATRIX 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)  C element / accumulator width (66)
// PORTS
//   clk                            in   1          rising-edge clock
//   resetn                         in   1          asynchronous, active-low reset
//   product_reg                    in   2*DW_INIT  unsigned product for current term
//   matrix_a_col_addr_counter_reg  in   clog2(K)   k index (A column)
//   matrix_b_row_addr_counter_reg  in   clog2(K)   k index (B row), equals A col
//   matrix_a_row_addr_counter_reg  in   clog2(M)   i index of current term
//   matrix_b_col_addr_counter_reg  in   clog2(N)   j index of current term
//   mult_done_reg                  in   1          product/indices valid this cycle
//   data_out_c                     out  DW_RES     finished C element
//   matrix_c_we                    out  1          C write strobe, 1 cycle per element
//   mac_done                       out  1          all M*N elements written (sticky)
//   row_addr_c                     out  clog2(M)   C row address for the write
//   col_addr_c                     out  clog2(N)   C column address for the write
// BEHAVIOUR
//   - Reset (async, resetn=0):
//     - accumulator=0, mac_done=0, matrix_c_we=0, data_out_c=0.
//     - A partial sum in flight is discarded.
//   - Valid cycle (mult_done_reg=1): sum = acc + zero-extended product_reg; unsigned, DW_RES wide, no overflow possible.
//   - last = mult_done_reg && matrix_a_col_addr_counter_reg==K-1.
//     - Only the A col index is decoded; the B row index is not checked.
//   - Outputs are combinational, valid from input change to next rising edge (zero latency):
//     - matrix_c_we = last.
//     - data_out_c = sum when last, else 0.
//     - row_addr_c = matrix_a_row_addr_counter_reg.
//     - col_addr_c = matrix_b_col_addr_counter_reg.
//   - Posedge update:
//     - last: acc<=0.
//     - valid and not last: acc<=sum.
//     - mult_done_reg=0: acc holds; no write.
//   - Term order: k ascends 0..K-1 per element; elements arrive in any (i,j) order, one dot product at a time.
//   - mac_done: set at posedge when last && i==M-1 && j==N-1; stays 1 until reset.
//     - Further valid terms after that still accumulate and write normally.
//   - K=1: every valid cycle is last; data_out_c = product_reg.
//   - Back-to-back elements need no idle cycle; acc clears on the same edge that commits the write.
// CONFIGURATION
//   MAC_STOP_ACCUM_OUTREG_EN defined:
//     - data_out_c, matrix_c_we, row_addr_c, col_addr_c are registered (1-cycle latency after last).
//     - All four reset to 0.
//     - mac_done rises together with the registered final write.
//   Undefined (default): combinational outputs as above.
// TESTING
//   - Reset: resetn=0 -> all outputs 0. Release; acc starts at 0.
//   - Single element: products 28,18,25,16 with k=0..3, i=0, j=0, valid each cycle.
//     - k=0..2: matrix_c_we=0.
//     - k=3: data_out_c=87, row=0, col=0, we=1.
//   - Back-to-back: next products 24,21,40,10 with j=1 -> data_out_c=95 at k=3 with no idle cycle between the two elements.
//   - Full 4x4x4 stream (64 terms, i then j then k ascending):
//     - exactly 16 write strobes.
//     - mac_done=1 after the term with i=3, j=3, k=3.
//   - Stall: drop mult_done_reg for 3 cycles mid-element -> acc holds, we=0, final sum unchanged.
//   - Mid-operation reset after k=1 -> next element sums only post-reset terms. Also cover width: products 2^64-1 x4 -> data_out_c = 4*(2^64-1) with no truncation.

Source files
------------

// File: rtl/mac_stop_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mac_stop_accumulator
//  Purpose  : Accumulate stage of a matrix-multiply engine, C = A * B.
//             Sums K consecutive pre-computed products A[i][k]*B[k][j] into
//             one C element and presents it, with its C address and a write
//             strobe, on the cycle of the last k term. Raises a sticky done
//             flag once C[M-1][N-1] has been written.
//  Ports    : clk, resetn (async, active low)
//             product_reg                    - unsigned product of this term
//             matrix_a_col_addr_counter_reg  - k index (decoded for "last")
//             matrix_b_row_addr_counter_reg  - k index of B (not decoded)
//             matrix_a_row_addr_counter_reg  - i index of this term
//             matrix_b_col_addr_counter_reg  - j index of this term
//             mult_done_reg                  - product/indices valid
//             data_out_c, matrix_c_we, row_addr_c, col_addr_c - C write port
//             mac_done                       - all M*N elements written
//  Config   : MAC_STOP_ACCUM_OUTREG_EN - when defined, the C write port is
//             registered (one cycle after the last term); otherwise it is
//             combinational with zero latency.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_stop_accumulator #(
    parameter int M                        = 4,
    parameter int K                        = 4,
    parameter int N                        = 4,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [2*DATA_WIDTH_INIT_MATRIX-1:0]    product_reg,
    input  logic [((K > 1) ? $clog2(K) : 1)-1:0]   matrix_a_col_addr_counter_reg,
    input  logic [((K > 1) ? $clog2(K) : 1)-1:0]   matrix_b_row_addr_counter_reg,
    input  logic [((M > 1) ? $clog2(M) : 1)-1:0]   matrix_a_row_addr_counter_reg,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]   matrix_b_col_addr_counter_reg,
    input  logic                                   mult_done_reg,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0]    data_out_c,
    output logic                                   matrix_c_we,
    output logic                                   mac_done,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0]   row_addr_c,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]   col_addr_c
);

    localparam int c_KW = (K > 1) ? $clog2(K) : 1;
    localparam int c_MW = (M > 1) ? $clog2(M) : 1;
    localparam int c_NW = (N > 1) ? $clog2(N) : 1;
    localparam int c_DR = DATA_WIDTH_RESULT_MATRIX;

    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(K - 1);
    localparam logic [c_MW-1:0] c_M_LAST = c_MW'(M - 1);
    localparam logic [c_NW-1:0] c_N_LAST = c_NW'(N - 1);

    logic [c_DR-1:0] r_acc;
    logic            r_mac_done;
    logic [c_DR-1:0] w_sum;
    logic            w_last;
    logic            w_final;

    // The B row index always mirrors the A column index, so only the A side
    // is decoded; the B index is intentionally left unused.
    logic w_unused_b_row;
    assign w_unused_b_row = ^matrix_b_row_addr_counter_reg;

    always_comb begin
        w_sum   = r_acc + c_DR'(product_reg);
        w_last  = mult_done_reg && (matrix_a_col_addr_counter_reg == c_K_LAST);
        w_final = w_last
                  && (matrix_a_row_addr_counter_reg == c_M_LAST)
                  && (matrix_b_col_addr_counter_reg == c_N_LAST);
    end

    // Accumulator clears on the same edge that commits a finished element,
    // so consecutive dot products need no idle cycle between them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc <= '0;
        end else if (w_last) begin
            r_acc <= '0;
        end else if (mult_done_reg) begin
            r_acc <= w_sum;
        end
    end

    // Done is sticky; further terms keep accumulating and writing normally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mac_done <= 1'b0;
        end else if (w_final) begin
            r_mac_done <= 1'b1;
        end
    end

    assign mac_done = r_mac_done;

`ifdef MAC_STOP_ACCUM_OUTREG_EN
    logic [c_DR-1:0] r_data_out_c;
    logic            r_matrix_c_we;
    logic [c_MW-1:0] r_row_addr_c;
    logic [c_NW-1:0] r_col_addr_c;

    // Registered write port: lands on the same edge that raises mac_done
    // for the final element.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_out_c  <= '0;
            r_matrix_c_we <= 1'b0;
            r_row_addr_c  <= '0;
            r_col_addr_c  <= '0;
        end else begin
            r_data_out_c  <= w_last ? w_sum : '0;
            r_matrix_c_we <= w_last;
            r_row_addr_c  <= matrix_a_row_addr_counter_reg;
            r_col_addr_c  <= matrix_b_col_addr_counter_reg;
        end
    end

    assign data_out_c  = r_data_out_c;
    assign matrix_c_we = r_matrix_c_we;
    assign row_addr_c  = r_row_addr_c;
    assign col_addr_c  = r_col_addr_c;
`else
    assign data_out_c  = w_last ? w_sum : '0;
    assign matrix_c_we = w_last;
    assign row_addr_c  = matrix_a_row_addr_counter_reg;
    assign col_addr_c  = matrix_b_col_addr_counter_reg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_stop_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_stop_accumulator
//  Purpose  : Self-checking bench for mac_stop_accumulator (default build,
//             combinational write port). Directed steps followed by a random
//             4x4x4 matrix product checked against C computed from A and B.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_stop_accumulator;

    localparam int M   = 4;
    localparam int K   = 4;
    localparam int N   = 4;
    localparam int DWI = 32;
    localparam int DWR = 2*DWI + 2;

    logic           clk = 1'b0;
    logic           resetn;
    logic [63:0]    product_reg;
    logic [1:0]     a_col, b_row, a_row, b_col;
    logic           mult_done_reg;
    logic [DWR-1:0] data_out_c;
    logic           matrix_c_we;
    logic           mac_done;
    logic [1:0]     row_addr_c, col_addr_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_stop_accumulator #(
        .M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DWI)
    ) dut (
        .clk                           (clk),
        .resetn                        (resetn),
        .product_reg                   (product_reg),
        .matrix_a_col_addr_counter_reg (a_col),
        .matrix_b_row_addr_counter_reg (b_row),
        .matrix_a_row_addr_counter_reg (a_row),
        .matrix_b_col_addr_counter_reg (b_col),
        .mult_done_reg                 (mult_done_reg),
        .data_out_c                    (data_out_c),
        .matrix_c_we                   (matrix_c_we),
        .mac_done                      (mac_done),
        .row_addr_c                    (row_addr_c),
        .col_addr_c                    (col_addr_c)
    );

    task automatic chk(input string tag, input logic [DWR-1:0] obs, input logic [DWR-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one term after the falling edge and let the outputs settle.
    task automatic drive(input logic v, input logic [63:0] p, input int i, input int j,
                         input int k, input int brow);
        @(negedge clk);
        mult_done_reg = v;
        product_reg   = p;
        a_row         = 2'(i);
        b_col         = 2'(j);
        a_col         = 2'(k);
        b_row         = 2'(brow);
        #1;
    endtask

    task automatic check_port(input string tag, input logic exp_we, input logic [DWR-1:0] exp_data,
                              input int i, input int j);
        chk({tag, ".we"},   DWR'(matrix_c_we), DWR'(exp_we));
        chk({tag, ".data"}, data_out_c,        exp_data);
        chk({tag, ".row"},  DWR'(row_addr_c),  DWR'(i));
        chk({tag, ".col"},  DWR'(col_addr_c),  DWR'(j));
    endtask

    // One full dot product; intermediate terms must not strobe, the last one
    // must present the expected total.
    task automatic element(input string tag, input logic [63:0] p0, input logic [63:0] p1,
                           input logic [63:0] p2, input logic [63:0] p3, input int i, input int j,
                           input logic [DWR-1:0] total, input bit rev_b);
        logic [63:0] p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        for (int k = 0; k < K; k++) begin
            drive(1'b1, p[k], i, j, k, rev_b ? (K - 1 - k) : k);
            if (k < K - 1) check_port($sformatf("%s.k%0d", tag, k), 1'b0, '0, i, j);
            else           check_port($sformatf("%s.k%0d", tag, k), 1'b1, total, i, j);
        end
    endtask

    logic [31:0]    mat_a [M][K];
    logic [31:0]    mat_b [K][N];
    logic [DWR-1:0] mat_c [M][N];
    int             n_we;

    initial begin
        resetn        = 1'b0;
        mult_done_reg = 1'b0;
        product_reg   = '0;
        a_col = '0; b_row = '0; a_row = '0; b_col = '0;

        // Reset state
        #1;
        chk("reset.data", data_out_c, '0);
        chk("reset.we",   DWR'(matrix_c_we), '0);
        chk("reset.done", DWR'(mac_done), '0);
        chk("reset.row",  DWR'(row_addr_c), '0);
        chk("reset.col",  DWR'(col_addr_c), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Single element and a back-to-back follower
        element("single", 64'd28, 64'd18, 64'd25, 64'd16, 0, 0, DWR'(87), 1'b0);
        element("b2b",    64'd24, 64'd21, 64'd40, 64'd10, 0, 1, DWR'(95), 1'b0);

        // Stall mid-element: idle cycles show k=3 with junk product, valid low
        drive(1'b1, 64'd7, 1, 0, 0, 0);
        check_port("stall.k0", 1'b0, '0, 1, 0);
        drive(1'b1, 64'd9, 1, 0, 1, 1);
        check_port("stall.k1", 1'b0, '0, 1, 0);
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, {$urandom, $urandom}, 1, 0, 3, 3);
            check_port($sformatf("stall.idle%0d", s), 1'b0, '0, 1, 0);
        end
        drive(1'b1, 64'd11, 1, 0, 2, 2);
        check_port("stall.k2", 1'b0, '0, 1, 0);
        drive(1'b1, 64'd13, 1, 0, 3, 3);
        check_port("stall.k3", 1'b1, DWR'(40), 1, 0);

        // Mid-element reset discards the partial sum
        drive(1'b1, 64'd100, 2, 2, 0, 0);
        drive(1'b1, 64'd200, 2, 2, 1, 1);
        @(negedge clk);
        resetn        = 1'b0;
        mult_done_reg = 1'b0;
        #1;
        chk("midrst.data", data_out_c, '0);
        chk("midrst.we",   DWR'(matrix_c_we), '0);
        @(negedge clk);
        resetn = 1'b1;
        element("postrst", 64'd5, 64'd6, 64'd7, 64'd8, 2, 2, DWR'(26), 1'b0);

        // Full-width products, B row index deliberately not tracking k
        element("width", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1,
                66'h3_FFFF_FFFF_FFFF_FFFC, 1'b1);
        chk("pre.done", DWR'(mac_done), '0);

        // Random 4x4x4 product with occasional stalls
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) mat_a[i][k] = $urandom;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) mat_b[k][j] = $urandom;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                mat_c[i][j] = '0;
                for (int k = 0; k < K; k++)
                    mat_c[i][j] += DWR'(64'(mat_a[i][k]) * 64'(mat_b[k][j]));
            end

        n_we = 0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < K; k++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        drive(1'b0, {$urandom, $urandom}, i, j, K - 1, K - 1);
                        chk("rnd.idle.we", DWR'(matrix_c_we), '0);
                    end
                    drive(1'b1, 64'(mat_a[i][k]) * 64'(mat_b[k][j]), i, j, k, k);
                    if (matrix_c_we) n_we++;
                    chk($sformatf("rnd.done.i%0dj%0dk%0d", i, j, k), DWR'(mac_done), '0);
                    if (k == K - 1)
                        check_port($sformatf("rnd.c%0d%0d", i, j), 1'b1, mat_c[i][j], i, j);
                end
        @(posedge clk);
        #1;
        chk("rnd.done.set", DWR'(mac_done), DWR'(1));
        chk("rnd.strobes",  DWR'(n_we), DWR'(16));

        // Terms after completion still accumulate; done stays set
        element("postdone", 64'd1, 64'd2, 64'd3, 64'd4, 0, 0, DWR'(10), 1'b0);
        drive(1'b0, '0, 0, 0, 0, 0);
        chk("postdone.done", DWR'(mac_done), DWR'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
